// File: rtl/opendvs_event_pkg.sv
// Shared definitions for the DVS event packer: slot layout, field offsets and FSM states.
package opendvs_event_pkg;

  localparam int SLOT_W         = 34;
  localparam int SLOT_VALID_BIT = 33;
  localparam int SLOT_POL_BIT   = 32;
  localparam int SLOT_X_LSB     = 24;
  localparam int SLOT_Y_LSB     = 16;
  localparam int SLOT_TS_LSB    = 0;

  typedef struct packed {
    logic        valid;
    logic        pol;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] ts;
  } slot_t;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/dvs_ts_counter.sv
// Free-running 16-bit event timestamp, advanced by a tick strobe and wrapping at 0xFFFF.
module dvs_ts_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  output logic [15:0] ts
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ts <= 16'h0000;
    end else if (tick) begin
      ts <= ts + 16'd1;
    end
  end

endmodule

// File: rtl/dvs_event_packer.sv
// Packs DVS address events into fixed-width FIFO words, emitting on a full word,
// an explicit flush or an idle timeout.
module dvs_event_packer
  import opendvs_event_pkg::*;
#(
  parameter int DWIDTH        = 136,
  parameter int EV_PER_WORD   = 4,
  parameter int FLUSH_TIMEOUT = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ev_valid,
  input  logic [7:0]                     ev_x,
  input  logic [7:0]                     ev_y,
  input  logic                           ev_pol,
  input  logic                           ts_tick,
  input  logic                           flush_req,
  input  logic                           full_fifo,
  output logic                           wr_en_fifo,
  output logic [DWIDTH-1:0]              wdata_fifo,
  output logic [15:0]                    drop_count,
  output logic [$clog2(EV_PER_WORD):0]   fill_level
);

  localparam int FLW = $clog2(EV_PER_WORD) + 1;
  localparam int IW  = $clog2(FLUSH_TIMEOUT) + 1;
  localparam logic [FLW-1:0] LAST_SLOT = FLW'(EV_PER_WORD - 1);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(FLUSH_TIMEOUT - 2);

  logic [15:0]        ts_value;
  state_t             state;
  logic [DWIDTH-1:0]  word_q;
  logic [FLW-1:0]     fill_q;
  logic [IW-1:0]      idle_q;
  logic [15:0]        drop_q;
  logic [SLOT_W-1:0]  new_slot;
  logic               accept;
  logic               last_slot;
  logic               do_flush;
  logic               timeout;

  dvs_ts_counter u_ts_counter (
    .clk  (clk),
    .rst  (rst),
    .tick (ts_tick),
    .ts   (ts_value)
  );

  // The event takes the timestamp as it stands this cycle, before any same-cycle tick.
  always_comb begin
    new_slot                        = '0;
    new_slot[SLOT_VALID_BIT]        = 1'b1;
    new_slot[SLOT_POL_BIT]          = ev_pol;
    new_slot[SLOT_X_LSB +: 8]       = ev_x;
    new_slot[SLOT_Y_LSB +: 8]       = ev_y;
    new_slot[SLOT_TS_LSB +: 16]     = ts_value;
  end

  assign accept    = (state == FILL) && ev_valid;
  assign last_slot = accept && (fill_q == LAST_SLOT);
  assign do_flush  = (state == FILL) && flush_req && ((fill_q != '0) || ev_valid);
  // Idle counter hits its last value on the edge that lands the write exactly FLUSH_TIMEOUT cycles after the last event.
  assign timeout   = (state == FILL) && !ev_valid && (fill_q != '0) && (idle_q == IDLE_LAST);

  // Reset gates the strobe so a pending word is never written while rst is high.
  assign wr_en_fifo = (state == EMIT) && !full_fifo && !rst;
  assign wdata_fifo = word_q;
  assign drop_count = drop_q;
  assign fill_level = fill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FILL;
      word_q <= '0;
      fill_q <= '0;
      idle_q <= '0;
      drop_q <= 16'h0000;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            for (int k = 0; k < EV_PER_WORD; k++) begin
              if (fill_q == FLW'(k)) begin
                word_q[k*SLOT_W +: SLOT_W] <= new_slot;
              end
            end
            fill_q <= fill_q + 1'b1;
            idle_q <= '0;
          end else if (fill_q != '0) begin
            idle_q <= idle_q + 1'b1;
          end
          if (last_slot || do_flush || timeout) begin
            state <= EMIT;
          end
        end
        EMIT: begin
          if (ev_valid && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
          end
          if (!full_fifo) begin
            state  <= FILL;
            word_q <= '0;
            fill_q <= '0;
            idle_q <= '0;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dvs_event_packer.sv
// Directed self-checking bench for dvs_event_packer with a shortened flush timeout.
module tb_dvs_event_packer;

  localparam int DW  = 136;
  localparam int EVW = 4;
  localparam int TO  = 16;

  logic            clk;
  logic            rst;
  logic            ev_valid;
  logic [7:0]      ev_x;
  logic [7:0]      ev_y;
  logic            ev_pol;
  logic            ts_tick;
  logic            flush_req;
  logic            full_fifo;
  logic            wr_en_fifo;
  logic [DW-1:0]   wdata_fifo;
  logic [15:0]     drop_count;
  logic [2:0]      fill_level;

  int checks;
  int errors;
  int wr_count;

  dvs_event_packer #(
    .DWIDTH        (DW),
    .EV_PER_WORD   (EVW),
    .FLUSH_TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ev_valid   (ev_valid),
    .ev_x       (ev_x),
    .ev_y       (ev_y),
    .ev_pol     (ev_pol),
    .ts_tick    (ts_tick),
    .flush_req  (flush_req),
    .full_fifo  (full_fifo),
    .wr_en_fifo (wr_en_fifo),
    .wdata_fifo (wdata_fifo),
    .drop_count (drop_count),
    .fill_level (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en_fifo === 1'b1) wr_count++;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ev_valid  = 1'b0;
    ev_x      = 8'h00;
    ev_y      = 8'h00;
    ev_pol    = 1'b0;
    ts_tick   = 1'b0;
    flush_req = 1'b0;
  endtask

  task automatic set_event(input logic [7:0] x, input logic [7:0] y, input logic pol);
    ev_valid = 1'b1;
    ev_x     = x;
    ev_y     = y;
    ev_pol   = pol;
  endtask

  function automatic logic [DW-1:0] put_slot(input logic [DW-1:0] w, input int k,
                                             input logic pol, input logic [7:0] x,
                                             input logic [7:0] y, input logic [15:0] ts);
    logic [DW-1:0] r;
    r = w;
    r[k*34 +: 34] = {1'b1, pol, x, y, ts};
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    full_fifo = 1'b0;
    cycle();
    cycle();
    @(negedge clk);
    checks++;
    if (wr_en_fifo !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %b expected 0", wr_en_fifo); end
    checks++;
    if (wdata_fifo !== '0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", wdata_fifo); end
    checks++;
    if (drop_count !== 16'h0000) begin errors++; $display("[TB] FAIL reset_drop: got %h expected 0", drop_count); end
    checks++;
    if (fill_level !== 3'd0) begin errors++; $display("[TB] FAIL reset_fill: got %0d expected 0", fill_level); end
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_full_word();
    logic [DW-1:0] exp_word;
    int start_wr;
    exp_word = '0;
    ts_tick = 1'b1;
    repeat (5) cycle();
    ts_tick = 1'b0;
    start_wr = wr_count;
    for (int i = 0; i < 4; i++) begin
      set_event(8'(i + 1), 8'h10, 1'b1);
      exp_word = put_slot(exp_word, i, 1'b1, 8'(i + 1), 8'h10, 16'h0005);
      @(negedge clk);
      checks++;
      if (fill_level !== 3'(i)) begin errors++; $display("[TB] FAIL full_fill_%0d: got %0d expected %0d", i, fill_level, i); end
      checks++;
      if (wr_en_fifo !== 1'b0) begin errors++; $display("[TB] FAIL full_early_wr_%0d: got %b expected 0", i, wr_en_fifo); end
      cycle();
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (wr_en_fifo !== 1'b1) begin errors++; $display("[TB] FAIL full_latency: got %b expected 1", wr_en_fifo); end
    checks++;
    if (wdata_fifo !== exp_word) begin errors++; $display("[TB] FAIL full_word: got %h expected %h", wdata_fifo, exp_word); end
    checks++;
    if (fill_level !== 3'd4) begin errors++; $display("[TB] FAIL full_fill_emit: got %0d expected 4", fill_level); end
    cycle();
    @(negedge clk);
    checks++;
    if (fill_level !== 3'd0) begin errors++; $display("[TB] FAIL full_fill_clear: got %0d expected 0", fill_level); end
    checks++;
    if (wdata_fifo !== '0) begin errors++; $display("[TB] FAIL full_word_clear: got %h expected 0", wdata_fifo); end
    cycle();
    checks++;
    if (wr_count - start_wr !== 1) begin errors++; $display("[TB] FAIL full_pulses: got %0d expected 1", wr_count - start_wr); end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] exp_word;
    int found;
    int c;
    exp_word = '0;
    exp_word = put_slot(exp_word, 0, 1'b0, 8'h07, 8'h08, 16'h0005);
    exp_word = put_slot(exp_word, 1, 1'b1, 8'h09, 8'h0A, 16'h0005);
    set_event(8'h07, 8'h08, 1'b0);
    cycle();
    set_event(8'h09, 8'h0A, 1'b1);
    cycle();
    clear_inputs();
    found = 0;
    c = 1;
    while (found == 0 && c <= 4 * TO) begin
      @(negedge clk);
      if (wr_en_fifo === 1'b1) found = c;
      else begin
        cycle();
        c++;
      end
    end
    checks++;
    if (found !== TO) begin errors++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", found, TO); end
    checks++;
    if (wdata_fifo !== exp_word) begin errors++; $display("[TB] FAIL timeout_word: got %h expected %h", wdata_fifo, exp_word); end
    cycle();
    cycle();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_word;
    int start_wr;
    int bad_stable;
    exp_word = '0;
    full_fifo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_event(8'(8'h21 + i), 8'h33, 1'b0);
      exp_word = put_slot(exp_word, i, 1'b0, 8'(8'h21 + i), 8'h33, 16'h0005);
      cycle();
    end
    clear_inputs();
    start_wr = wr_count;
    bad_stable = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 3 || c == 7 || c == 11) set_event(8'hFF, 8'hFF, 1'b1);
      else clear_inputs();
      @(negedge clk);
      if (wdata_fifo !== exp_word) bad_stable++;
      cycle();
    end
    clear_inputs();
    checks++;
    if (wr_count - start_wr !== 0) begin errors++; $display("[TB] FAIL bp_no_write: got %0d writes expected 0", wr_count - start_wr); end
    checks++;
    if (bad_stable !== 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d unstable cycles expected 0", bad_stable); end
    full_fifo = 1'b0;
    @(negedge clk);
    checks++;
    if (drop_count !== 16'd3) begin errors++; $display("[TB] FAIL bp_drop: got %0d expected 3", drop_count); end
    checks++;
    if (wr_en_fifo !== 1'b1) begin errors++; $display("[TB] FAIL bp_release: got %b expected 1", wr_en_fifo); end
    checks++;
    if (wdata_fifo !== exp_word) begin errors++; $display("[TB] FAIL bp_word: got %h expected %h", wdata_fifo, exp_word); end
    cycle();
    @(negedge clk);
    checks++;
    if (wr_en_fifo !== 1'b0) begin errors++; $display("[TB] FAIL bp_single: got %b expected 0", wr_en_fifo); end
    cycle();
  endtask

  task automatic test_ts_wrap();
    logic [DW-1:0] exp_word;
    exp_word = '0;
    exp_word = put_slot(exp_word, 0, 1'b1, 8'h40, 8'h41, 16'hFFFF);
    exp_word = put_slot(exp_word, 1, 1'b0, 8'h42, 8'h43, 16'h0000);
    ts_tick = 1'b1;
    repeat (16'hFFFF - 16'h0005) cycle();
    set_event(8'h40, 8'h41, 1'b1);
    cycle();
    ts_tick = 1'b0;
    set_event(8'h42, 8'h43, 1'b0);
    flush_req = 1'b1;
    cycle();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (wr_en_fifo !== 1'b1) begin errors++; $display("[TB] FAIL wrap_flush_wr: got %b expected 1", wr_en_fifo); end
    checks++;
    if (wdata_fifo[15:0] !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_slot0_ts: got %h expected ffff", wdata_fifo[15:0]); end
    checks++;
    if (wdata_fifo[49:34] !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_slot1_ts: got %h expected 0000", wdata_fifo[49:34]); end
    checks++;
    if (wdata_fifo !== exp_word) begin errors++; $display("[TB] FAIL wrap_word: got %h expected %h", wdata_fifo, exp_word); end
    cycle();
  endtask

  task automatic test_flush();
    logic [DW-1:0] exp_word;
    int start_wr;
    exp_word = '0;
    exp_word = put_slot(exp_word, 0, 1'b1, 8'h55, 8'h66, 16'h0000);
    start_wr = wr_count;
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    repeat (3) cycle();
    checks++;
    if (wr_count - start_wr !== 0) begin errors++; $display("[TB] FAIL flush_empty: got %0d writes expected 0", wr_count - start_wr); end
    @(negedge clk);
    checks++;
    if (fill_level !== 3'd0) begin errors++; $display("[TB] FAIL flush_empty_fill: got %0d expected 0", fill_level); end
    cycle();
    set_event(8'h55, 8'h66, 1'b1);
    flush_req = 1'b1;
    cycle();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (wr_en_fifo !== 1'b1) begin errors++; $display("[TB] FAIL flush_one_wr: got %b expected 1", wr_en_fifo); end
    checks++;
    if (wdata_fifo !== exp_word) begin errors++; $display("[TB] FAIL flush_one_word: got %h expected %h", wdata_fifo, exp_word); end
    checks++;
    if (fill_level !== 3'd1) begin errors++; $display("[TB] FAIL flush_one_fill: got %0d expected 1", fill_level); end
    cycle();
  endtask

  task automatic test_reset_in_emit();
    int start_wr;
    full_fifo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_event(8'(8'h70 + i), 8'h01, 1'b1);
      cycle();
    end
    clear_inputs();
    start_wr = wr_count;
    @(negedge clk);
    checks++;
    if (wr_en_fifo !== 1'b0) begin errors++; $display("[TB] FAIL rst_emit_held: got %b expected 0", wr_en_fifo); end
    cycle();
    rst = 1'b1;
    full_fifo = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_en_fifo !== 1'b0) begin errors++; $display("[TB] FAIL rst_dominates: got %b expected 0", wr_en_fifo); end
    cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_en_fifo !== 1'b0 || wdata_fifo !== '0 || fill_level !== 3'd0 || drop_count !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL rst_outputs: got wr=%b data=%h fill=%0d drop=%0d expected all zero",
               wr_en_fifo, wdata_fifo, fill_level, drop_count);
    end
    repeat (3) cycle();
    checks++;
    if (wr_count - start_wr !== 0) begin errors++; $display("[TB] FAIL rst_discard: got %0d writes expected 0", wr_count - start_wr); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    wr_count = 0;
    rst      = 1'b1;
    full_fifo = 1'b0;
    clear_inputs();
    $display("[TB] starting dvs_event_packer bench");
    test_reset();
    test_full_word();
    test_timeout();
    test_backpressure();
    test_ts_wrap();
    test_flush();
    test_reset_in_emit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvs_event_packer.md
DVS_EVENT_PACKER -- requirements
Module: dvs_event_packer

Interface
REQ-001 SHALL have parameter DWIDTH, default 136, FIFO word width; must equal EV_PER_WORD*34.
REQ-002 SHALL have parameter EV_PER_WORD, default 4, event slots per FIFO word.
REQ-003 SHALL have parameter FLUSH_TIMEOUT, default 1024, idle cycles before a partial word is flushed.
REQ-004 SHALL use one clock, clk; reset is synchronous and active-high, named rst.
REQ-005 Port list:
  clk  input  1  rising-edge clock.
  rst  input  1  synchronous active-high reset.
  ev_valid  input  1  event strobe, one event per asserted cycle.
  ev_x  input  8  event column.
  ev_y  input  8  event row.
  ev_pol  input  1  event polarity, 1 = ON.
  ts_tick  input  1  timestamp increment strobe.
  flush_req  input  1  force emit of a partial word.
  full_fifo  input  1  downstream sync FIFO full.
  wr_en_fifo  output  1  FIFO write strobe.
  wdata_fifo  output  DWIDTH  packed word.
  drop_count  output  16  saturating count of dropped events.
  fill_level  output  $clog2(EV_PER_WORD)+1  slots currently occupied.

Function
REQ-006 Slot format, 34 bits: [33] slot valid, [32] pol, [31:24] x, [23:16] y, [15:0] timestamp; slot k occupies wdata_fifo[34k+33:34k].
REQ-007 Internal 16-bit timestamp SHALL increment on ts_tick and wrap 0xFFFF -> 0x0000.
REQ-008 Event and ts_tick in the same cycle: the event SHALL carry the pre-increment timestamp.
REQ-009 FSM states: FILL and EMIT; reset state FILL.
REQ-010 In FILL, ev_valid SHALL write slot[fill_level] with valid=1, and fill_level SHALL increment the next cycle.
REQ-011 FILL -> EMIT when the accepted event fills slot EV_PER_WORD-1.
REQ-012 FILL -> EMIT when fill_level>0 and flush_req=1; if an event is accepted in the same cycle, it SHALL be included first.
REQ-013 flush_req with fill_level=0 and no event SHALL be ignored.
REQ-014 Idle counter SHALL reset on every accepted event and count while in FILL with fill_level>0; on reaching FLUSH_TIMEOUT-1, FILL -> EMIT.
REQ-015 Unfilled slots at emit SHALL be all-zero (valid=0).
REQ-016 In EMIT, wr_en_fifo = !full_fifo (combinational); wdata_fifo SHALL be stable for the whole EMIT state.
REQ-017 EMIT -> FILL on the cycle wr_en_fifo=1; slots and fill_level SHALL clear the next cycle.
REQ-018 Latency: last slot filled in cycle N -> wr_en_fifo=1 in cycle N+1 if full_fifo=0.
REQ-019 full_fifo held high SHALL keep the block in EMIT indefinitely; wr_en_fifo=0 throughout.
REQ-020 No backpressure: ev_valid in EMIT SHALL be dropped and increment drop_count, saturating at 0xFFFF.
REQ-021 wr_en_fifo SHALL never assert while full_fifo=1.

Reset
REQ-022 Reset SHALL set: state=FILL, slots=0, fill_level=0, timestamp=0, idle counter=0, drop_count=0, wr_en_fifo=0, wdata_fifo=0.
REQ-023 Reset mid-EMIT SHALL discard the pending word without a write; reset dominates all inputs in the same cycle.

Structure
REQ-024 Package opendvs_event_pkg SHALL hold: SLOT_W=34, field offsets, the slot struct typedef and the FILL/EMIT state enum.
REQ-025 The timestamp counter SHALL be a sub-module, dvs_ts_counter (16-bit, tick enable, sync reset).
REQ-026 The block SHALL connect directly to the sync FIFO wr_en_fifo/wdata_fifo/full_fifo ports.

Verification
REQ-027 Four events (x=1..4, y=0x10, pol=1), ts=0x0005, full_fifo=0 -> exactly one wr_en_fifo pulse one cycle after the 4th event; slot k = {1,1,k+1,0x10,0x0005}.
REQ-028 Two events then idle -> wr_en_fifo exactly FLUSH_TIMEOUT cycles after the 2nd event; slots 2,3 = 0.
REQ-029 Four events with full_fifo=1 for 20 cycles, 3 ev_valid pulses during that time -> no write until full_fifo drops, drop_count=3, word unchanged.
REQ-030 Timestamp at 0xFFFF: ts_tick and an event in the same cycle -> slot ts=0xFFFF, next event ts=0x0000.
REQ-031 flush_req with one event accepted in the same cycle -> word with slot0 valid, others 0; flush_req with fill_level=0 -> no write.
REQ-032 rst asserted during EMIT -> no wr_en_fifo; all outputs zero the following cycle.
